// File: rtl/cache_refill_ctrl.sv
// Block refill and write-through drain toward main memory.
// Define CACHE_REFILL_CWF_EN to fetch the critical word first.
module cache_refill_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 2,
  parameter int WBUF_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           miss_req,
  input  logic [ADDR_WIDTH-1:0]          miss_addr,
  output logic                           refill_valid,
  output logic [$clog2(BLOCK_WORDS)-1:0] refill_idx,
  output logic [DATA_WIDTH-1:0]          refill_data,
  output logic                           refill_done,
  input  logic                           wt_valid,
  output logic                           wt_ready,
  input  logic [ADDR_WIDTH-1:0]          wt_addr,
  input  logic [DATA_WIDTH-1:0]          wt_data,
  output logic                           mem_req_valid,
  input  logic                           mem_req_ready,
  output logic                           mem_req_we,
  output logic [ADDR_WIDTH-1:0]          mem_req_addr,
  output logic [DATA_WIDTH-1:0]          mem_req_wdata,
  input  logic                           mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]          mem_resp_data
);

  localparam int IDX_W  = $clog2(BLOCK_WORDS);
  localparam int OFF    = IDX_W + 2;
  localparam int BASE_W = ADDR_WIDTH - OFF;
  localparam int WA_W   = ADDR_WIDTH - 2;
  localparam int PW     = $clog2(WBUF_DEPTH);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DRAIN = 3'd1;
  localparam logic [2:0] REQ   = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic              post_done_q;
  logic [BASE_W-1:0] base_q;
  logic [IDX_W-1:0]  word_q;
  logic [IDX_W-1:0]  beat_q;
  logic [IDX_W-1:0]  start_word;

  logic [WA_W-1:0]       wbuf_addr [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] wbuf_data [WBUF_DEPTH];
  logic [PW:0]           wr_ptr;
  logic [PW:0]           rd_ptr;
  logic [PW:0]           fill_cnt;

  logic empty;
  logic full;
  logic last_entry;
  logic push;
  logic pop;
  logic drain_act;
  logic rd_act;
  logic miss_go;
  logic last_beat;
  logic unused_addr_bits;

`ifdef CACHE_REFILL_CWF_EN
  assign start_word = miss_addr[OFF-1:2];
`else
  assign start_word = '0;
`endif

  assign unused_addr_bits = ^{miss_addr[OFF-1:0], wt_addr[1:0]};

  assign fill_cnt   = wr_ptr - rd_ptr;
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[PW] != rd_ptr[PW]) &&
                      (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign last_entry = (fill_cnt == (PW+1)'(1));

  assign wt_ready  = !full && (state_q == IDLE);
  assign push      = wt_valid && wt_ready;
  assign drain_act = ((state_q == IDLE) || (state_q == DRAIN)) && !empty;
  assign rd_act    = (state_q == REQ);
  assign pop       = drain_act && mem_req_ready;

  // A miss in the cycle right after DONE would re-fetch the same block.
  assign miss_go   = miss_req && !post_done_q;
  assign last_beat = (beat_q == IDX_W'(BLOCK_WORDS - 1));

  assign refill_valid = (state_q == WAIT) && mem_resp_valid;
  assign refill_idx   = refill_valid ? word_q : '0;
  assign refill_data  = refill_valid ? mem_resp_data : '0;
  assign refill_done  = (state_q == DONE);

  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    unique case (1'b1)
      drain_act: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {wbuf_addr[rd_ptr[PW-1:0]], 2'b00};
        mem_req_wdata = wbuf_data[rd_ptr[PW-1:0]];
      end
      rd_act: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {base_q, word_q, 2'b00};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (miss_go) begin
          if (empty || (pop && last_entry)) state_d = REQ;
          else                              state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (empty || (pop && last_entry)) state_d = REQ;
      end
      REQ: begin
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) state_d = last_beat ? DONE : REQ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      post_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      post_done_q <= (state_q == DONE);
    end
  end

  // Block base is latched so a dropped miss_req cannot disturb the refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      word_q <= '0;
      beat_q <= '0;
    end else if ((state_q == IDLE) && miss_go) begin
      base_q <= miss_addr[ADDR_WIDTH-1:OFF];
      word_q <= start_word;
      beat_q <= '0;
    end else if (refill_valid) begin
      word_q <= word_q + IDX_W'(1);
      beat_q <= beat_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        wbuf_addr[i] <= '0;
        wbuf_data[i] <= '0;
      end
    end else if (push) begin
      wbuf_addr[wr_ptr[PW-1:0]] <= wt_addr[ADDR_WIDTH-1:2];
      wbuf_data[wr_ptr[PW-1:0]] <= wt_data;
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: vector table plus
// hand sequences for drain ordering, backpressure and reset.
module tb_cache_refill_ctrl;

`ifdef CACHE_REFILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  localparam logic [31:0] K = 32'hC0DE_0000;

  logic        clk;
  logic        rst_n;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic        refill_valid;
  logic [0:0]  refill_idx;
  logic [31:0] refill_data;
  logic        refill_done;
  logic        wt_valid;
  logic        wt_ready;
  logic [31:0] wt_addr;
  logic [31:0] wt_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  cache_refill_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .miss_req      (miss_req),
    .miss_addr     (miss_addr),
    .refill_valid  (refill_valid),
    .refill_idx    (refill_idx),
    .refill_data   (refill_data),
    .refill_done   (refill_done),
    .wt_valid      (wt_valid),
    .wt_ready      (wt_ready),
    .wt_addr       (wt_addr),
    .wt_data       (wt_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        miss;
    logic [31:0] maddr;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        wv;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        e_mv;
    logic        e_we;
    logic [31:0] e_ma;
    logic [31:0] e_md;
    logic        e_rv;
    logic [31:0] e_ri;
    logic [31:0] e_rd;
    logic        e_done;
    logic        e_wr;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  vec_t        vecs[$];
  req_t        req_q[$];
  req_t        exp_q[$];
  logic [31:0] ridx_q[$];
  logic [31:0] rdat_q[$];
  int          checks = 0;
  int          errors = 0;
  int          wt_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic void add(
    input logic miss, input logic [31:0] maddr, input logic rdy,
    input logic rv, input logic [31:0] rd,
    input logic wv, input logic [31:0] wa, input logic [31:0] wd,
    input logic e_mv, input logic e_we, input logic [31:0] e_ma,
    input logic [31:0] e_md, input logic e_rv, input logic [31:0] e_ri,
    input logic [31:0] e_rd, input logic e_done, input logic e_wr);
    vec_t v;
    v.miss = miss; v.maddr = maddr; v.rdy = rdy;
    v.rv = rv; v.rd = rd; v.wv = wv; v.wa = wa; v.wd = wd;
    v.e_mv = e_mv; v.e_we = e_we; v.e_ma = e_ma; v.e_md = e_md;
    v.e_rv = e_rv; v.e_ri = e_ri; v.e_rd = e_rd;
    v.e_done = e_done; v.e_wr = e_wr;
    vecs.push_back(v);
  endfunction

  // Memory model: accepts every request, answers reads one cycle later.
  task automatic service(input string tag, input int budget,
                         input bit chk_wt);
    bit          pend = 1'b0;
    bit          seen = 1'b0;
    logic [31:0] paddr = '0;
    req_q.delete();
    ridx_q.delete();
    rdat_q.delete();
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      mem_req_ready  = 1'b1;
      mem_resp_valid = pend;
      mem_resp_data  = pend ? (paddr ^ K) : 32'h0;
      pend = 1'b0;
      #1;
      if (refill_valid) begin
        ridx_q.push_back(32'(refill_idx));
        rdat_q.push_back(refill_data);
      end
      if (mem_req_valid && mem_req_ready) begin
        req_q.push_back({mem_req_we, mem_req_addr, mem_req_wdata});
        if (!mem_req_we) begin
          pend  = 1'b1;
          paddr = mem_req_addr;
        end
      end
      if (refill_done) seen = 1'b1;
      else if (chk_wt && wt_ready) wt_bad++;
    end
    chk({tag, " refill_done seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    miss_req       = 1'b0;
  endtask

  task automatic cmp_log(input string tag);
    int nr = 0;
    chk({tag, " request count"}, 32'(req_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < req_q.size(); i++) begin
      chk($sformatf("%s req%0d we", tag, i),
          32'(req_q[i].we), 32'(exp_q[i].we));
      chk($sformatf("%s req%0d addr", tag, i),
          req_q[i].addr, exp_q[i].addr);
      if (exp_q[i].we)
        chk($sformatf("%s req%0d wdata", tag, i),
            req_q[i].wdata, exp_q[i].wdata);
      else begin
        if (nr < ridx_q.size()) begin
          chk($sformatf("%s refill%0d idx", tag, nr),
              ridx_q[nr], 32'(exp_q[i].addr[2]));
          chk($sformatf("%s refill%0d data", tag, nr),
              rdat_q[nr], exp_q[i].addr ^ K);
        end
        nr++;
      end
    end
    chk({tag, " refill count"}, 32'(ridx_q.size()), 32'(nr));
  endtask

  function automatic req_t rq(input logic we, input logic [31:0] a,
                              input logic [31:0] d);
    req_t r;
    r.we = we; r.addr = a; r.wdata = d;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] i0;
    logic [31:0] i1;

    a0 = CWF ? 32'h104 : 32'h100;
    a1 = CWF ? 32'h100 : 32'h104;
    i0 = CWF ? 32'd1 : 32'd0;
    i1 = CWF ? 32'd0 : 32'd1;

    // Miss 0x104, ready=1, 1-cycle response: done five cycles later.
    add(1, 32'h104, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 32'h104, 1, 0, 0, 0, 0, 0, 1, 0, a0, 0, 0, 0, 0, 0, 0);
    add(1, 32'h104, 1, 1, 32'h1111_0000, 0, 0, 0,
        0, 0, 0, 0, 1, i0, 32'h1111_0000, 0, 0);
    add(1, 32'h104, 1, 0, 0, 0, 0, 0, 1, 0, a1, 0, 0, 0, 0, 0, 0);
    add(1, 32'h104, 1, 1, 32'h2222_0001, 0, 0, 0,
        0, 0, 0, 0, 1, i1, 32'h2222_0001, 0, 0);
    add(1, 32'h104, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 32'h104, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Fill the buffer with memory stalled, then drain in order.
    add(0, 0, 0, 0, 0, 1, 32'h10, 32'h11,
        0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 32'h17, 32'h22,
        1, 1, 32'h10, 32'h11, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 32'h18, 32'h33,
        1, 1, 32'h10, 32'h11, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 32'h1C, 32'h44,
        1, 1, 32'h10, 32'h11, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 32'h20, 32'h55,
        1, 1, 32'h10, 32'h11, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1, 32'h20, 32'h55,
        1, 1, 32'h10, 32'h11, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0,
        1, 1, 32'h14, 32'h22, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0,
        1, 1, 32'h18, 32'h33, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0,
        1, 1, 32'h1C, 32'h44, 0, 0, 0, 0, 1);
    add(0, 0, 1, 1, 32'hBAD0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0, 1);

    rst_n = 1'b0;
    miss_req = 0; miss_addr = '0;
    wt_valid = 0; wt_addr = '0; wt_data = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset wt_ready", 32'(wt_ready), 32'd1);
    chk("reset mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("reset mem_req_addr", mem_req_addr, 32'd0);
    chk("reset refill_valid", 32'(refill_valid), 32'd0);
    chk("reset refill_done", 32'(refill_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      miss_req       = vecs[i].miss;
      miss_addr      = vecs[i].maddr;
      mem_req_ready  = vecs[i].rdy;
      mem_resp_valid = vecs[i].rv;
      mem_resp_data  = vecs[i].rd;
      wt_valid       = vecs[i].wv;
      wt_addr        = vecs[i].wa;
      wt_data        = vecs[i].wd;
      #1;
      chk($sformatf("v%0d mem_req_valid", i),
          32'(mem_req_valid), 32'(vecs[i].e_mv));
      chk($sformatf("v%0d refill_valid", i),
          32'(refill_valid), 32'(vecs[i].e_rv));
      chk($sformatf("v%0d refill_done", i),
          32'(refill_done), 32'(vecs[i].e_done));
      chk($sformatf("v%0d wt_ready", i),
          32'(wt_ready), 32'(vecs[i].e_wr));
      if (vecs[i].e_mv) begin
        chk($sformatf("v%0d mem_req_we", i),
            32'(mem_req_we), 32'(vecs[i].e_we));
        chk($sformatf("v%0d mem_req_addr", i),
            mem_req_addr, vecs[i].e_ma);
        if (vecs[i].e_we)
          chk($sformatf("v%0d mem_req_wdata", i),
              mem_req_wdata, vecs[i].e_md);
      end
      if (vecs[i].e_rv) begin
        chk($sformatf("v%0d refill_idx", i),
            32'(refill_idx), vecs[i].e_ri);
        chk($sformatf("v%0d refill_data", i),
            refill_data, vecs[i].e_rd);
      end
    end
    @(negedge clk);
    wt_valid = 0; mem_resp_valid = 0; mem_req_ready = 0;

    // Two queued stores must reach memory before the refill reads.
    @(negedge clk);
    wt_valid = 1; wt_addr = 32'h40; wt_data = 32'hA;
    @(negedge clk);
    wt_addr = 32'h44; wt_data = 32'hB;
    @(negedge clk);
    wt_valid = 0;
    miss_req = 1; miss_addr = 32'h200;
    #1;
    service("drain", 40, 1'b1);
    chk("drain wt_ready held low", 32'(wt_bad), 32'd0);
    exp_q.delete();
    exp_q.push_back(rq(1, 32'h40, 32'hA));
    exp_q.push_back(rq(1, 32'h44, 32'hB));
    exp_q.push_back(rq(0, 32'h200, 0));
    exp_q.push_back(rq(0, 32'h204, 0));
    cmp_log("drain");

    // Stalled read request with a stray response in REQ.
    @(negedge clk);
    miss_req = 1; miss_addr = 32'h404; mem_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_resp_valid = (i == 0);
      mem_resp_data  = 32'hBAD0_BAD0;
      #1;
      chk($sformatf("stall%0d mem_req_valid", i),
          32'(mem_req_valid), 32'd1);
      chk($sformatf("stall%0d mem_req_addr", i), mem_req_addr,
          CWF ? 32'h404 : 32'h400);
      chk($sformatf("stall%0d refill_valid", i),
          32'(refill_valid), 32'd0);
    end
    service("stall", 30, 1'b0);
    exp_q.delete();
    exp_q.push_back(rq(0, CWF ? 32'h404 : 32'h400, 0));
    exp_q.push_back(rq(0, CWF ? 32'h400 : 32'h404, 0));
    cmp_log("stall");

    // Reset in WAIT abandons the block; the next miss starts clean.
    @(negedge clk);
    miss_req = 1; miss_addr = 32'h30C; mem_req_ready = 1;
    @(negedge clk);
    @(negedge clk);
    miss_req = 0;
    #2;
    rst_n = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h5555_5555;
    #1;
    chk("midreset refill_valid", 32'(refill_valid), 32'd0);
    chk("midreset refill_done", 32'(refill_done), 32'd0);
    chk("midreset mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("midreset wt_ready", 32'(wt_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    miss_req = 1; miss_addr = 32'h308;
    #1;
    service("postreset", 30, 1'b0);
    exp_q.delete();
    exp_q.push_back(rq(0, 32'h308, 0));
    exp_q.push_back(rq(0, 32'h30C, 0));
    cmp_log("postreset");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
